label_ram_mp: RTL

Multi-channel garbled-label store that generalises the two-port label RAM to P request channels over one inferred true-dual-port memory. Per-address ready flags are set when a write commits; a write buffer absorbs write bursts; reads are arbitrated onto the two memory ports. It sits between the gate-evaluation lanes and label storage in the garbled-circuit engine, so more than two lanes can share one memory.

---
 rtl/label_ram_mp.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/label_ram_mp.sv
// Multi-channel garbled-label store: P write channels feed a commit FIFO, and
// reads and FIFO commits share the two ports of one read-first dual-port RAM.
module label_ram_mp #(
    parameter int S = 10,
    parameter int K = 128,
    parameter int P = 4,
    parameter int Q = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic [P-1:0]   wr_en,
    input  logic [P*S-1:0] wr_addr,
    input  logic [P*K-1:0] wr_data,
    output logic           wr_stall,
    input  logic [P-1:0]   rd_req,
    input  logic [P*S-1:0] rd_addr,
    output logic [P-1:0]   rd_ready,
    output logic [P-1:0]   rd_stall,
    output logic [P-1:0]   rd_valid,
    output logic [P*K-1:0] rd_data,
    output logic           wr_err
);
    localparam int D   = 2 ** S;
    localparam int CW  = $clog2(Q + 1);
    localparam int CHW = (P > 1) ? $clog2(P) : 1;
    localparam int QS  = (Q < 2) ? 2 : Q;

    typedef struct packed {
        logic [S-1:0] addr;
        logic [K-1:0] data;
    } ent_t;

    ent_t                  buf_q [QS];
    ent_t                  buf_d [QS];
    logic [CW-1:0]         occ_q, occ_d;
    logic [D-1:0]          flag_q, flag_d;
    logic                  wr_stall_q, wr_stall_d;
    logic                  wr_err_q, wr_err_d;
    logic                  ga_vld_q, ga_vld_d, gb_vld_q, gb_vld_d;
    logic [CHW-1:0]        ga_ch_q, ga_ch_d, gb_ch_q, gb_ch_d;
    logic [P-1:0][K-1:0]   hold_q, hold_d;

    logic [K-1:0]          mem [D];
    logic [K-1:0]          qa_q, qb_q;
    logic [S-1:0]          a_addr, b_addr;
    logic [K-1:0]          a_wd, b_wd;
    logic                  a_we, b_we;

    always_comb begin
        int   occ, ngr, nfree, ndeq, wp, src;
        logic drain, ca, cb;
        ent_t ea, eb;
        logic [S-1:0] ra0, ra1;

        occ      = int'(occ_q);
        drain    = occ > Q - P;
        rd_stall = rd_req;
        ga_vld_d = 1'b0;
        gb_vld_d = 1'b0;
        ga_ch_d  = '0;
        gb_ch_d  = '0;
        ra0      = '0;
        ra1      = '0;
        ngr      = 0;
        for (int i = 0; i < P; i++) begin
            rd_ready[i] = flag_q[rd_addr[i*S +: S]];
            if (!drain && rd_req[i] && ngr < 2) begin
                rd_stall[i] = 1'b0;
                if (ngr == 0) begin
                    ga_vld_d = 1'b1;
                    ga_ch_d  = CHW'(i);
                    ra0      = rd_addr[i*S +: S];
                end else begin
                    gb_vld_d = 1'b1;
                    gb_ch_d  = CHW'(i);
                    ra1      = rd_addr[i*S +: S];
                end
                ngr++;
            end
        end

        // Ports not claimed by a read drain the FIFO, A taking the oldest entry.
        nfree = 2 - ngr;
        ndeq  = (occ < nfree) ? occ : nfree;
        ca    = (ndeq >= 1) && !ga_vld_d;
        cb    = (ndeq == 2) || (ndeq == 1 && ga_vld_d);
        ea    = buf_q[0];
        eb    = ca ? buf_q[1] : buf_q[0];

        a_addr = ga_vld_d ? ra0 : ea.addr;
        b_addr = gb_vld_d ? ra1 : eb.addr;
        a_wd   = ea.data;
        b_wd   = eb.data;
        // On a same-address pair only the younger entry (port B) lands.
        a_we   = ca && !(cb && ea.addr == eb.addr) && !rst && !clr;
        b_we   = cb && !rst && !clr;

        flag_d = flag_q;
        if (ca) flag_d[ea.addr] = 1'b1;
        if (cb) flag_d[eb.addr] = 1'b1;

        buf_d = buf_q;
        for (int j = 0; j < QS; j++) begin
            src = j + ndeq;
            if (src < QS) buf_d[j] = buf_q[src];
        end
        wp       = occ - ndeq;
        wr_err_d = wr_err_q | (wr_stall_q & (|wr_en));
        for (int i = 0; i < P; i++) begin
            if (wr_en[i] && !wr_stall_q) begin
                for (int j = 0; j < QS; j++)
                    if (j == wp) buf_d[j] = '{addr: wr_addr[i*S +: S], data: wr_data[i*K +: K]};
                wp++;
            end
        end
        occ_d      = CW'(wp);
        wr_stall_d = wp > Q - P;

        if (clr) begin
            occ_d      = '0;
            flag_d     = '0;
            wr_stall_d = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < P; i++) begin
            rd_valid[i]       = (ga_vld_q && ga_ch_q == CHW'(i)) || (gb_vld_q && gb_ch_q == CHW'(i));
            rd_data[i*K +: K] = (ga_vld_q && ga_ch_q == CHW'(i)) ? qa_q :
                                (gb_vld_q && gb_ch_q == CHW'(i)) ? qb_q : hold_q[i];
            hold_d[i]         = rd_data[i*K +: K];
        end
    end

    assign wr_stall = wr_stall_q;
    assign wr_err   = wr_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q      <= '0;
            flag_q     <= '0;
            wr_stall_q <= 1'b0;
            wr_err_q   <= 1'b0;
            ga_vld_q   <= 1'b0;
            gb_vld_q   <= 1'b0;
            ga_ch_q    <= '0;
            gb_ch_q    <= '0;
            hold_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            flag_q     <= flag_d;
            wr_stall_q <= wr_stall_d;
            wr_err_q   <= wr_err_d;
            ga_vld_q   <= ga_vld_d;
            gb_vld_q   <= gb_vld_d;
            ga_ch_q    <= ga_ch_d;
            gb_ch_q    <= gb_ch_d;
            hold_q     <= hold_d;
        end
    end

    // Storage without reset so the array maps onto block RAM; reads are read-first.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
        if (a_we) mem[a_addr] <= a_wd;
        if (b_we) mem[b_addr] <= b_wd;
        qa_q <= mem[a_addr];
        qb_q <= mem[b_addr];
    end
endmodule
